// File: rtl/bictr_dcnto_mode_if.sv
// Control/status bundle for the mode-selectable up/down counter.
// The master drives the load/step controls; the slave returns the count and event flags.
interface bictr_dcnto_mode_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] count_to;
  logic             up_dn;
  logic             load;
  logic             cen;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tercnt;
  logic             tc_pulse;
  logic             wrap;
  logic             done;

  modport master (
    output data, count_to, up_dn, load, cen, mode,
    input  count, tercnt, tc_pulse, wrap, done
  );

  modport slave (
    input  data, count_to, up_dn, load, cen, mode,
    output count, tercnt, tc_pulse, wrap, done
  );
endinterface

// File: rtl/bictr_dcnto_mode.sv
// Up/down counter with dynamic count-to, four terminal modes (wrap, modulo,
// saturate, one-shot), parallel load and registered tc/wrap/done events.
module bictr_dcnto_mode #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bictr_dcnto_mode_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_MODULO  = 2'd1,
    MODE_SAT     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  mode_e            mode_s;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_q, tc_nxt;
  logic             wrap_q, wrap_nxt;
  logic             done_q, done_nxt;

  function automatic logic [WIDTH-1:0] step_wrap(input logic [WIDTH-1:0] c, input logic up);
    return up ? c + WIDTH'(1) : c - WIDTH'(1);
  endfunction

  function automatic logic is_rollover(input logic [WIDTH-1:0] c, input logic up);
    return up ? (c == ALL_ONES) : (c == ZERO);
  endfunction

  assign mode_s = mode_e'(bus.mode);

  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    tc_nxt    = 1'b0;
    done_nxt  = done_q;
    if (bus.load) begin
      count_nxt = bus.data;
      done_nxt  = 1'b0;
    end else if (bus.cen) begin
      case (mode_s)
        MODE_WRAP: begin
          count_nxt = step_wrap(count_q, bus.up_dn);
          wrap_nxt  = is_rollover(count_q, bus.up_dn);
        end
        MODE_MODULO: begin
          if (bus.up_dn && count_q == bus.count_to) begin
            count_nxt = ZERO;
            wrap_nxt  = 1'b1;
          end else if (!bus.up_dn && count_q == ZERO) begin
            count_nxt = bus.count_to;
            wrap_nxt  = 1'b1;
          end else begin
            // Above count_to the up count falls through to the natural rollover.
            count_nxt = step_wrap(count_q, bus.up_dn);
            wrap_nxt  = is_rollover(count_q, bus.up_dn);
          end
        end
        MODE_SAT: begin
          if (bus.up_dn) begin
            if (count_q != bus.count_to && count_q != ALL_ONES)
              count_nxt = count_q + WIDTH'(1);
          end else if (count_q != ZERO) begin
            count_nxt = count_q - WIDTH'(1);
          end
        end
        MODE_ONESHOT: begin
          if (!done_q) begin
            count_nxt = step_wrap(count_q, bus.up_dn);
            wrap_nxt  = is_rollover(count_q, bus.up_dn);
            if (count_nxt == bus.count_to)
              done_nxt = 1'b1;
          end
        end
        default: ;
      endcase
      // Only a real move onto count_to pulses; holds at the terminal stay quiet.
      tc_nxt = (count_nxt == bus.count_to) && (count_nxt != count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
      wrap_q  <= wrap_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.count    = count_q;
  assign bus.tercnt   = (count_q == bus.count_to);
  assign bus.tc_pulse = tc_q;
  assign bus.wrap     = wrap_q;
  assign bus.done     = done_q;

endmodule
